// File: rtl/tx_arbiter.sv
// Round-robin packet arbiter merging N byte-stream requesters onto one UART TX stream.
// Define TX_ARBITER_TAG_EN to prefix every packet with header byte 8'hA0 | owner.
module tx_arbiter #(
  parameter int N       = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_stb,
  input  logic [8*N-1:0] req_dat,
  input  logic [N-1:0]   req_lst,
  output logic [N-1:0]   req_rdy,
  output logic           tx_stb,
  output logic [7:0]     tx_dat,
  input  logic           tx_rdy,
  output logic [1:0]     owner,
  output logic           busy,
  output logic           err
);

`ifdef TX_ARBITER_TAG_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_HEAD = 2'd2} state_t;
`else
  typedef enum logic {S_IDLE = 1'b0, S_DATA = 1'b1} state_t;
`endif

  state_t      r_state;
  logic [1:0]  r_ptr;
  logic [15:0] r_cnt;

  logic        w_own_stb;
  logic        w_own_lst;
  logic [7:0]  w_own_dat;
  logic        w_gnt_vld;
  logic [1:0]  w_gnt_idx;
  logic [1:0]  w_nxt_ptr;
  logic [15:0] w_cnt_nxt;
  logic        w_tmo;
  logic        w_slot_free;
  logic        w_accept;

  always_comb begin
    w_own_stb = 1'b0;
    w_own_lst = 1'b0;
    w_own_dat = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (owner == 2'(i)) begin
        w_own_stb = req_stb[i];
        w_own_lst = req_lst[i];
        w_own_dat = req_dat[8*i +: 8];
      end
    end
  end

  // Scan distances from far to near so the requester closest to r_ptr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int unsigned k = N; k > 0; k--) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (req_stb[i] && ((32'(r_ptr) + k - 1) % N == i)) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = 2'(i);
        end
      end
    end
  end

  assign w_slot_free = !tx_stb || tx_rdy;
  assign w_accept    = (r_state == S_DATA) && w_slot_free && w_own_stb;
  assign w_nxt_ptr   = (owner == 2'(N-1)) ? '0 : owner + 2'd1;
  assign w_cnt_nxt   = r_cnt + 16'd1;
  assign w_tmo       = (w_cnt_nxt == 16'(TIMEOUT));

  always_comb begin
    req_rdy = '0;
    for (int unsigned i = 0; i < N; i++) begin
      req_rdy[i] = (r_state == S_DATA) && w_slot_free && (owner == 2'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      owner   <= '0;
      busy    <= 1'b0;
      err     <= 1'b0;
      tx_stb  <= 1'b0;
      tx_dat  <= '0;
    end else begin
      err <= 1'b0;
      if (w_accept) begin
        tx_stb <= 1'b1;
        tx_dat <= w_own_dat;
      end else if (tx_rdy) begin
        tx_stb <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_gnt_vld) begin
            owner <= w_gnt_idx;
            busy  <= 1'b1;
`ifdef TX_ARBITER_TAG_EN
            r_state <= S_HEAD;
`else
            r_state <= S_DATA;
`endif
          end
        end
`ifdef TX_ARBITER_TAG_EN
        S_HEAD: begin
          if (w_slot_free) begin
            tx_stb  <= 1'b1;
            tx_dat  <= 8'hA0 | {6'd0, owner};
            r_state <= S_DATA;
          end
        end
`endif
        S_DATA: begin
          if (w_accept) begin
            r_cnt <= '0;
            if (w_own_lst) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
              r_ptr   <= w_nxt_ptr;
            end
          end else if (!w_own_stb) begin
            // Only owner silence counts; a stalled transmitter leaves r_cnt alone.
            if (w_tmo) begin
              err     <= 1'b1;
              r_state <= S_IDLE;
              busy    <= 1'b0;
              r_ptr   <= w_nxt_ptr;
              r_cnt   <= '0;
            end else begin
              r_cnt <= w_cnt_nxt;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter (N=2, TIMEOUT=4); header bytes expected when TX_ARBITER_TAG_EN is defined.
module tb_tx_arbiter;
  localparam int N   = 2;
  localparam int TMO = 4;
`ifdef TX_ARBITER_TAG_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_stb, req_lst, req_rdy;
  logic [8*N-1:0] req_dat;
  logic           tx_stb, tx_rdy;
  logic [7:0]     tx_dat;
  logic [1:0]     owner;
  logic           busy, err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_err  = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] txq[$];
  logic [7:0] expq[$];
  logic [7:0] hold;
  bit         found;

  always #5 clk = ~clk;

  tx_arbiter #(.N(N), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_stb(req_stb), .req_dat(req_dat), .req_lst(req_lst), .req_rdy(req_rdy),
    .tx_stb(tx_stb), .tx_dat(tx_dat), .tx_rdy(tx_rdy),
    .owner(owner), .busy(busy), .err(err)
  );

  // Requester models present their queue heads away from the active edge.
  always @(negedge clk) begin
    req_stb = '0; req_lst = '0; req_dat = '0;
    if (q0.size() != 0) begin
      req_stb[0] = 1'b1; req_lst[0] = q0[0][8]; req_dat[7:0] = q0[0][7:0];
    end
    if (q1.size() != 0) begin
      req_stb[1] = 1'b1; req_lst[1] = q1[0][8]; req_dat[15:8] = q1[0][7:0];
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (req_stb[0] && req_rdy[0]) void'(q0.pop_front());
      if (req_stb[1] && req_rdy[1]) void'(q1.pop_front());
      if (tx_stb && tx_rdy) txq.push_back(tx_dat);
      if (err) n_err++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic exp_hdr(input int o);
    if (H != 0) expq.push_back(8'hA0 | 8'(o));
  endtask

  task automatic wait_drain(input int n);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (txq.size() >= n && !busy && !tx_stb && q0.size() == 0 && q1.size() == 0) break;
    end
  endtask

  task automatic cmp_txq(input string tag);
    chk({tag, "_len"}, txq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < txq.size(); i++) chk(tag, txq[i], expq[i]);
  endtask

  task automatic wait_tx(input logic [7:0] d);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx_stb && tx_dat == d) begin found = 1'b1; break; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; tx_rdy = 1'b1;
    req_stb = '0; req_lst = '0; req_dat = '0;
    @(negedge clk);
    chk("rst_tx_stb", tx_stb, 0);
    chk("rst_tx_dat", tx_dat, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_err", err, 0);
    chk("rst_req_rdy", req_rdy, 0);

    // Single packet on req0, first grant right after reset release
    q0.push_back(9'h011); q0.push_back(9'h022); q0.push_back(9'h133);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("sp_busy", busy, 1);
    chk("sp_owner", owner, 0);
    chk("sp_idle_stb", tx_stb, 0);
`ifdef TX_ARBITER_TAG_EN
    @(negedge clk);
    chk("sp_hdr", tx_dat, 8'hA0);
`endif
    @(negedge clk);
    chk("sp_b0_stb", tx_stb, 1);
    chk("sp_b0", tx_dat, 8'h11);
    chk("sp_rdy", req_rdy, 2'b01);
    @(negedge clk); chk("sp_b1", tx_dat, 8'h22);
    @(negedge clk); chk("sp_b2", tx_dat, 8'h33);
    chk("sp_busy_drop", busy, 0);
    @(negedge clk); chk("sp_stb_clr", tx_stb, 0);

    // ptr is now 1: req1 wins a simultaneous request
    txq.delete(); expq.delete();
    q0.push_back(9'h140); q1.push_back(9'h141);
    exp_hdr(1); expq.push_back(8'h41); exp_hdr(0); expq.push_back(8'h40);
    wait_drain(expq.size());
    cmp_txq("rr_ptr");

    // Contention from reset: packets alternate starting with req0
    rst_n = 1'b0;
    txq.delete(); expq.delete();
    q0.push_back(9'h001); q0.push_back(9'h102); q0.push_back(9'h005); q0.push_back(9'h106);
    q1.push_back(9'h003); q1.push_back(9'h104); q1.push_back(9'h007); q1.push_back(9'h108);
    exp_hdr(0); expq.push_back(8'h01); expq.push_back(8'h02);
    exp_hdr(1); expq.push_back(8'h03); expq.push_back(8'h04);
    exp_hdr(0); expq.push_back(8'h05); expq.push_back(8'h06);
    exp_hdr(1); expq.push_back(8'h07); expq.push_back(8'h08);
    @(negedge clk); rst_n = 1'b1;
    wait_drain(expq.size());
    cmp_txq("contend");

    // Backpressure longer than TIMEOUT with owner still strobing
    txq.delete(); expq.delete();
    q0.push_back(9'h010); q0.push_back(9'h020); q0.push_back(9'h130);
    exp_hdr(0); expq.push_back(8'h10); expq.push_back(8'h20); expq.push_back(8'h30);
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_stb) begin found = 1'b1; break; end
    end
    chk("bp_seen", found, 1);
    tx_rdy = 1'b0;
    hold = tx_dat;
    repeat (5) begin
      @(negedge clk);
      chk("bp_dat", tx_dat, hold);
      chk("bp_stb", tx_stb, 1);
      chk("bp_req_rdy", req_rdy, 0);
    end
    tx_rdy = 1'b1;
    wait_drain(expq.size());
    cmp_txq("bp");
    chk("bp_no_err", n_err, 0);

    // Timeout: req0 stops mid-packet, req1 takes over after the err pulse
    txq.delete(); expq.delete();
    q0.push_back(9'h077);
    exp_hdr(0); expq.push_back(8'h77); exp_hdr(1); expq.push_back(8'h88);
    wait_tx(8'h77);
    chk("tmo_seen", found, 1);
    q1.push_back(9'h188);
    @(negedge clk); chk("tmo_err_c1", err, 0);
    @(negedge clk); chk("tmo_err_c2", err, 0);
    @(negedge clk); chk("tmo_err_c3", err, 0);
    @(negedge clk); chk("tmo_err_c4", err, 1);
    chk("tmo_busy_drop", busy, 0);
    @(negedge clk);
    chk("tmo_err_end", err, 0);
    chk("tmo_owner", owner, 1);
    chk("tmo_busy", busy, 1);
    wait_drain(expq.size());
    cmp_txq("tmo");
    chk("tmo_err_cnt", n_err, 1);

    // Reset in the middle of a req1 packet
    q0.push_back(9'h130);
    wait_drain(1);
    txq.delete(); expq.delete();
    q1.push_back(9'h031); q1.push_back(9'h032); q1.push_back(9'h133);
    wait_tx(8'h32);
    chk("rm_seen", found, 1);
    rst_n = 1'b0;
    #1;
    chk("rm_tx_stb", tx_stb, 0);
    chk("rm_tx_dat", tx_dat, 8'h00);
    chk("rm_busy", busy, 0);
    chk("rm_owner", owner, 0);
    chk("rm_req_rdy", req_rdy, 0);
    q0.delete(); q1.delete(); txq.delete();
    q1.push_back(9'h161);
    exp_hdr(1); expq.push_back(8'h61); exp_hdr(0); expq.push_back(8'h62);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rm_owner_after", owner, 1);
    chk("rm_busy_after", busy, 1);
    q0.push_back(9'h162);
    wait_drain(expq.size());
    cmp_txq("rm");

    // Single-byte packet from req1 (header-prefixed in tagged builds)
    txq.delete(); expq.delete();
    q1.push_back(9'h155);
    exp_hdr(1); expq.push_back(8'h55);
    wait_drain(expq.size());
    cmp_txq("tag");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
